wb_write_queue: RTL and testbench
=================================

# wb_write_queue

Write-back side queue for the 8-entry register file: accepts completed results (destination register, data) from the execute/memory stages through a valid/ready handshake, buffers up to DEPTH of them in order, and drains one per cycle onto the register file write port (regWrite, WA, WD). It also publishes a per-register pending bitmap so decode can detect RAW hazards against queued writes. It can optionally forward queued data to decode's two read ports.

## Interface
- W, 16, data width; must match the register file width.
- DEPTH, 4, queue entries; a power of two and at least 2.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  producer has a result to write.
- in_ready  out  1  queue can accept; equals !full.
- in_addr  in  3  destination register index.
- in_data  in  W  result data.
- wr_hold  in  1  blocks draining for this cycle, because the write port is unavailable.
- regWrite  out  1  register file write enable.
- WA  out  3  register file write address (head entry).
- WD  out  W  register file write data (head entry).
- pending  out  8  bit i is set if any valid entry targets register i.
- count  out  $clog2(DEPTH)+1  number of valid entries.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- byp_src_addr, byp_dst_addr  in  3 each  decode read addresses.
- byp_src_hit, byp_dst_hit  out  1 each  a queued entry matches.
- byp_src_data, byp_dst_data  out  W each  data from the youngest matching entry.

## Operation
- Circular FIFO with head/tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH. A separate count register disambiguates full from empty.
- Push on a rising edge when in_valid && in_ready. The entry is written at the tail and tail increments.
- regWrite = !empty && !wr_hold, combinationally. WA and WD always show the head entry, even when regWrite is 0.
- Pop on a rising edge when regWrite is 1. The head entry is invalidated and head increments.
- Push while full is refused (in_ready=0), even if a pop occurs in the same cycle.
- Push and pop in the same cycle when not full: both happen and count is unchanged.
- pending is a combinational OR of the one-hot destination decodes over all valid entries. Duplicate destinations keep the bit set until the last matching entry drains.
- Writes reach the register file in strict acceptance order.
- Bypass priority: the youngest valid matching entry (the one closest to tail) wins. The head entry still counts as matching during its drain cycle.
- Reset, including mid-operation: all entries are invalidated and their storage cleared, head=tail=count=0. Outputs become regWrite=0, WA=0, WD=0, pending=0, empty=1, full=0, in_ready=1, all hits 0, all bypass data 0. Any in-flight push or pop is discarded.

## Timing
- Latency:
  - A push on edge k into an empty queue gives regWrite=1 during cycle k→k+1.
  - The register file captures the data on edge k+1.
- Throughput: one write per cycle sustained while wr_hold=0.
- pending, count, full, empty and in_ready reflect state after the most recent edge, with no extra delay.
- Bypass outputs are purely combinational from the byp_*_addr inputs and the current queue state.
- wr_hold asserted for n cycles delays the head write by exactly n cycles and causes no loss.

## Configuration
- WB_BYPASS_EN defined: the bypass match logic is compiled in as described above.
- WB_BYPASS_EN undefined: the bypass ports remain for interface stability but are tied to 0 (hits=0, data=0). No comparators are synthesized, and decode must stall on pending instead.

## Structure
- The shared package proc_pkg holds:
  - REG_ADDR_W=3 and NUM_REGS=8;
  - the typedef wb_entry_t {addr[REG_ADDR_W-1:0], data[W-1:0]}, with W passed by parameterization.
- The pending bitmap reuses the codebase's existing Decoder (3→8) once per entry.
- One sub-module is natural: wb_youngest_match. It is instantiated twice, once per read port. It scans entries from tail-1 back to head and returns hit and data; it exists only under WB_BYPASS_EN.

## Test plan
- Reset then idle: with rst pulsed mid-cycle and no pushes, expect regWrite=0, WA=0, WD=0, pending=8'h00, empty=1, count=0, in_ready=1.
- Single write: push (addr 3, data 16'hBEEF) on edge 1. Expect regWrite=1, WA=3, WD=16'hBEEF during cycle 1→2, pending=8'h08 until edge 2, and empty again after edge 2.
- Fill and refuse: push addr 1,2,3,4 with wr_hold=1. Expect full=1 and in_ready=0; a fifth push (addr 5) is dropped. Then release wr_hold and expect WA sequence 1,2,3,4 on consecutive cycles.
- Duplicate destination: push (2, 16'h0001) then (2, 16'h0002) with wr_hold=1.
  - pending[2] stays 1 until both entries drain.
  - With WB_BYPASS_EN and byp_src_addr=2, expect byp_src_hit=1 and byp_src_data=16'h0002.
- Simultaneous push/pop at count=2: expect count to stay 2, the order to be preserved, and the tail and head pointers to wrap correctly past DEPTH-1.
- Reset mid-drain: with 3 entries queued, assert rst asynchronously. Expect regWrite to drop to 0 immediately and no further writes after release; pending=0.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared processor constants and the write-back entry type.
package proc_pkg;
  localparam int REG_ADDR_W = 3;
  localparam int NUM_REGS   = 8;
  localparam int WB_W       = 16;

  // Default-width entry. Modules with a different data width build their own
  // entry layout from REG_ADDR_W and their W parameter.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [WB_W-1:0]       data;
  } wb_entry_t;
endpackage

// File: rtl/decoder.sv
// Register index to one-hot decoder (3->8). It has an enable input, and when the enable is low the output is all zeros.
module Decoder
  import proc_pkg::*;
(
  input  logic                  en,
  input  logic [REG_ADDR_W-1:0] sel,
  output logic [NUM_REGS-1:0]   y
);
  always_comb begin
    y = '0;
    if (en) y[sel] = 1'b1;
  end
endmodule

// File: rtl/wb_youngest_match.sv
// Finds the youngest valid queue entry whose destination matches addr.
// It is used only when the design is built with WB_BYPASS_EN.
module wb_youngest_match
  import proc_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]                 valid,
  input  logic [DEPTH-1:0][REG_ADDR_W-1:0] addrs,
  input  logic [DEPTH-1:0][W-1:0]          datas,
  input  logic [PW-1:0]                    head,
  input  logic [REG_ADDR_W-1:0]            addr,
  output logic                             hit,
  output logic [W-1:0]                     data
);
  logic [PW-1:0] idx;

  // The scan runs from oldest to youngest. A later match overrides an earlier one, so the entry closest to tail wins.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (valid[idx] && (addrs[idx] == addr)) begin
        hit  = 1'b1;
        data = datas[idx];
      end
    end
  end
endmodule

// File: rtl/wb_write_queue.sv
// In-order write-back queue in front of the register file write port.
// Define WB_BYPASS_EN to compile in forwarding to the decode read ports.
module wb_write_queue
  import proc_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [REG_ADDR_W-1:0]    in_addr,
  input  logic [W-1:0]             in_data,
  input  logic                     wr_hold,
  output logic                     regWrite,
  output logic [REG_ADDR_W-1:0]    WA,
  output logic [W-1:0]             WD,
  output logic [NUM_REGS-1:0]      pending,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  input  logic [REG_ADDR_W-1:0]    byp_src_addr,
  input  logic [REG_ADDR_W-1:0]    byp_dst_addr,
  output logic                     byp_src_hit,
  output logic                     byp_dst_hit,
  output logic [W-1:0]             byp_src_data,
  output logic [W-1:0]             byp_dst_data
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Handshake: a push happens on an edge where in_valid && in_ready. A pop happens on an edge where regWrite is high.
  logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_addr;
  logic [DEPTH-1:0][W-1:0]          ent_data;
  logic [DEPTH-1:0]                 valid;
  logic [PW-1:0]                    head;
  logic [PW-1:0]                    tail;
  logic [CW-1:0]                    cnt;
  logic                             push;
  logic                             pop;

  assign full     = (cnt == CW'(DEPTH));
  assign empty    = (cnt == '0);
  assign in_ready = !full;
  assign count    = cnt;
  assign push     = in_valid && in_ready;
  assign regWrite = !empty && !wr_hold;
  assign pop      = regWrite;
  assign WA       = ent_addr[head];
  assign WD       = ent_data[head];

  // A push and a pop never target the same slot. A pop needs a non-empty queue and a push needs a non-full queue, and head equals tail only when the queue is empty or full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_addr <= '0;
      ent_data <= '0;
      valid    <= '0;
      head     <= '0;
      tail     <= '0;
      cnt      <= '0;
    end else begin
      if (push) begin
        ent_addr[tail] <= in_addr;
        ent_data[tail] <= in_data;
        valid[tail]    <= 1'b1;
        tail           <= tail + 1'b1;
      end
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= head + 1'b1;
      end
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  logic [DEPTH-1:0][NUM_REGS-1:0] dec_y;

  for (genvar g = 0; g < DEPTH; g++) begin : g_dec
    Decoder u_dec (
      .en  (valid[g]),
      .sel (ent_addr[g]),
      .y   (dec_y[g])
    );
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) pending = pending | dec_y[i];
  end

`ifdef WB_BYPASS_EN
  wb_youngest_match #(.W(W), .DEPTH(DEPTH)) u_match_src (
    .valid (valid),
    .addrs (ent_addr),
    .datas (ent_data),
    .head  (head),
    .addr  (byp_src_addr),
    .hit   (byp_src_hit),
    .data  (byp_src_data)
  );

  wb_youngest_match #(.W(W), .DEPTH(DEPTH)) u_match_dst (
    .valid (valid),
    .addrs (ent_addr),
    .datas (ent_data),
    .head  (head),
    .addr  (byp_dst_addr),
    .hit   (byp_dst_hit),
    .data  (byp_dst_data)
  );
`else
  // The ports stay so the interface does not change. Decode must stall on pending instead of forwarding.
  logic byp_unused;
  assign byp_unused   = ^{byp_src_addr, byp_dst_addr};
  assign byp_src_hit  = 1'b0;
  assign byp_dst_hit  = 1'b0;
  assign byp_src_data = '0;
  assign byp_dst_data = '0;
`endif
endmodule

// File: tb/tb_wb_write_queue.sv
// Directed and random stimulus for wb_write_queue, checked against a queue model.
module tb_wb_write_queue;
  localparam int W     = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_addr;
  logic [W-1:0]  in_data;
  logic          wr_hold;
  logic          regWrite;
  logic [2:0]    WA;
  logic [W-1:0]  WD;
  logic [7:0]    pending;
  logic [2:0]    count;
  logic          full;
  logic          empty;
  logic [2:0]    byp_src_addr;
  logic [2:0]    byp_dst_addr;
  logic          byp_src_hit;
  logic          byp_dst_hit;
  logic [W-1:0]  byp_src_data;
  logic [W-1:0]  byp_dst_data;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // Model of the queue contents. Each entry is {addr, data}, and the front of the queue is the head.
  logic [W+2:0] exp_q[$];

  wb_write_queue #(.W(W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_addr      (in_addr),
    .in_data      (in_data),
    .wr_hold      (wr_hold),
    .regWrite     (regWrite),
    .WA           (WA),
    .WD           (WD),
    .pending      (pending),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .byp_src_addr (byp_src_addr),
    .byp_dst_addr (byp_dst_addr),
    .byp_src_hit  (byp_src_hit),
    .byp_dst_hit  (byp_dst_hit),
    .byp_src_data (byp_src_data),
    .byp_dst_data (byp_dst_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pending_model();
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < exp_q.size(); i++) p[exp_q[i][W+2:W]] = 1'b1;
    return p;
  endfunction

  function automatic logic [W:0] byp_model(input logic [2:0] a);
    logic [W:0] r;
    r = '0;
`ifdef WB_BYPASS_EN
    for (int i = 0; i < exp_q.size(); i++)
      if (exp_q[i][W+2:W] == a) r = {1'b1, exp_q[i][W-1:0]};
`endif
    return r;
  endfunction

  // The model advances on the same edges as the DUT, using only the stimulus.
  always @(posedge clk or posedge rst) begin
    if (rst) exp_q.delete();
    else begin
      automatic bit do_pop  = (exp_q.size() != 0) && !wr_hold;
      automatic bit do_push = in_valid && (exp_q.size() < DEPTH);
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back({in_addr, in_data});
    end
  end

  // Mid-cycle scoreboard check of every output
  always @(negedge clk) begin
    if (!rst) begin
      automatic logic exp_wr = (exp_q.size() != 0) && !wr_hold;
      automatic logic [W:0] bs = byp_model(byp_src_addr);
      automatic logic [W:0] bd = byp_model(byp_dst_addr);
      chk("regWrite", 32'(regWrite), 32'(exp_wr));
      if (exp_q.size() != 0) begin
        chk("WA", 32'(WA), 32'(exp_q[0][W+2:W]));
        chk("WD", 32'(WD), 32'(exp_q[0][W-1:0]));
      end
      chk("count", 32'(count), 32'(exp_q.size()));
      chk("full", 32'(full), 32'(exp_q.size() == DEPTH));
      chk("empty", 32'(empty), 32'(exp_q.size() == 0));
      chk("in_ready", 32'(in_ready), 32'(exp_q.size() < DEPTH));
      chk("pending", 32'(pending), 32'(pending_model()));
      chk("src_hit", 32'(byp_src_hit), 32'(bs[W]));
      chk("src_data", 32'(byp_src_data), 32'(bs[W-1:0]));
      chk("dst_hit", 32'(byp_dst_hit), 32'(bd[W]));
      chk("dst_data", 32'(byp_dst_data), 32'(bd[W-1:0]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] a, input logic [W-1:0] d);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_regWrite"}, 32'(regWrite), 32'd0);
    chk({tag, "_WA"}, 32'(WA), 32'd0);
    chk({tag, "_WD"}, 32'(WD), 32'd0);
    chk({tag, "_pending"}, 32'(pending), 32'h00);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_src_hit"}, 32'(byp_src_hit), 32'd0);
    chk({tag, "_src_data"}, 32'(byp_src_data), 32'd0);
  endtask

  initial begin
    rst          = 1'b1;
    in_valid     = 1'b0;
    in_addr      = '0;
    in_data      = '0;
    wr_hold      = 1'b0;
    byp_src_addr = '0;
    byp_dst_addr = '0;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // The reset pulse lands between clock edges, and no pushes are made afterwards.
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    #1 chk_reset_outputs("idle");
    tick();

    // Single write
    push(3'd3, 16'hBEEF);
    chk("single_regWrite", 32'(regWrite), 32'd1);
    chk("single_WA", 32'(WA), 32'd3);
    chk("single_WD", 32'(WD), 32'hBEEF);
    chk("single_pending", 32'(pending), 32'h08);
    tick();
    chk("single_empty", 32'(empty), 32'd1);
    chk("single_pending_clr", 32'(pending), 32'h00);

    // The queue fills while the write port is held. A push to a full queue is refused.
    wr_hold = 1'b1;
    for (int i = 1; i <= 4; i++) push(3'(i), 16'(16'h1000 + i));
    in_valid = 1'b1;
    in_addr  = 3'd5;
    in_data  = 16'h5555;
    #1;
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    tick();
    in_valid = 1'b0;
    chk("fill_count", 32'(count), 32'd4);
    wr_hold = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      #1 chk("fill_WA_order", 32'(WA), 32'(i));
      tick();
    end
    chk("fill_drained", 32'(empty), 32'd1);

    // Two entries have the same destination register, and the youngest one is forwarded.
    wr_hold = 1'b1;
    push(3'd2, 16'h0001);
    push(3'd2, 16'h0002);
    byp_src_addr = 3'd2;
    #1;
    chk("dup_pending", 32'(pending), 32'h04);
`ifdef WB_BYPASS_EN
    chk("dup_src_hit", 32'(byp_src_hit), 32'd1);
    chk("dup_src_data", 32'(byp_src_data), 32'h0002);
`else
    chk("dup_src_hit", 32'(byp_src_hit), 32'd0);
    chk("dup_src_data", 32'(byp_src_data), 32'h0000);
`endif
    wr_hold = 1'b0;
    tick();
    chk("dup_pending_one_left", 32'(pending), 32'h04);
    tick();
    chk("dup_pending_clr", 32'(pending), 32'h00);

    // Push and pop in the same cycle with two entries queued. The pointers wrap past DEPTH-1.
    wr_hold = 1'b1;
    push(3'd6, 16'hA000);
    push(3'd7, 16'hA001);
    wr_hold = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_addr  = 3'(i);
      in_data  = 16'(16'hB000 + i);
      tick();
      chk("pp_count", 32'(count), 32'd2);
    end
    in_valid = 1'b0;
    repeat (3) tick();

    // Reset is asserted asynchronously while the queue is draining.
    wr_hold = 1'b1;
    push(3'd5, 16'hC005);
    push(3'd6, 16'hC006);
    push(3'd7, 16'hC007);
    wr_hold = 1'b0;
    #1 rst = 1'b1;
    #1 chk_reset_outputs("mid_drain");
    #2 rst = 1'b0;
    repeat (3) tick();

    // Random traffic
    for (int i = 0; i < 80; i++) begin
      in_valid     = 1'($urandom_range(0, 1));
      in_addr      = 3'($urandom_range(0, 7));
      in_data      = 16'($urandom_range(0, 16'hFFFF));
      wr_hold      = ($urandom_range(0, 3) == 0);
      byp_src_addr = 3'($urandom_range(0, 7));
      byp_dst_addr = 3'($urandom_range(0, 7));
      tick();
    end
    in_valid = 1'b0;
    wr_hold  = 1'b0;
    repeat (6) tick();
    chk("final_empty", 32'(empty), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
